// File: rtl/timer_pkg.sv
// rtl/timer_pkg.sv - shared constants and counter state type for the APB timer
package timer_pkg;

   localparam int CNT_W   = 64;
   localparam int DIV_MAX = 8;

   localparam logic [11:0] TCR_ADDR   = 12'h000;
   localparam logic [11:0] TDR0_ADDR  = 12'h004;
   localparam logic [11:0] TDR1_ADDR  = 12'h008;
   localparam logic [11:0] THCSR_ADDR = 12'h00C;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      HALT = 2'd2
   } cnt_state_t;

endpackage

// File: rtl/timer_prescaler.sv
// rtl/timer_prescaler.sv - 2^div_val prescaler producing the counter tick
// pcnt advances only while run is high and is forced to 0 by clear.
module timer_prescaler #(
   parameter int DIV_MAX = timer_pkg::DIV_MAX
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       run,
   input  logic       clear,
   input  logic       div_en,
   input  logic [3:0] div_val,
   output logic       tick
);

   logic [DIV_MAX-1:0] pcnt_q, pcnt_d;
   logic [DIV_MAX-1:0] term;
   logic [DIV_MAX:0]   one_hot;

   always_comb begin
      // Terminal count is 2^div_val - 1; one extra bit keeps div_val == DIV_MAX exact.
      one_hot = (DIV_MAX+1)'(1) << div_val;
      term    = DIV_MAX'(one_hot - (DIV_MAX+1)'(1));
      tick    = run && (!div_en || (div_val == 4'd0) || (pcnt_q == term));

      pcnt_d = pcnt_q;
      if (clear) begin
         pcnt_d = '0;
      end else if (tick) begin
         pcnt_d = '0;
      end else if (run) begin
         pcnt_d = pcnt_q + DIV_MAX'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pcnt_q <= '0;
      end else begin
         pcnt_q <= pcnt_d;
      end
   end

endmodule

// File: rtl/timer_counter.sv
// rtl/timer_counter.sv - 64-bit timer counting stage with byte-lane load and debug halt
// Per-cycle priority is disable-clear, then TDR load, then prescaler tick.
module timer_counter #(
   parameter int CNT_W   = timer_pkg::CNT_W,
   parameter int DIV_MAX = timer_pkg::DIV_MAX
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             timer_en,
   input  logic             div_en,
   input  logic [3:0]       div_val,
   input  logic             tdr0_wr_sel,
   input  logic             tdr1_wr_sel,
   input  logic [31:0]      wdata,
   input  logic [3:0]       pstrb,
   input  logic             halt_req,
   input  logic             dbg_mode,
   output logic [CNT_W-1:0] cnt_value,
   output logic             halt_ack,
   output logic             cnt_tick
);

   import timer_pkg::*;

   if (CNT_W != 64) begin : g_cnt_w_check
      $error("timer_counter: CNT_W must be 64");
   end

   cnt_state_t       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             tick_q, tick_d;
   logic             ack_q, ack_d;
   logic             halt_hit, run, disable_clr, load, tick;

   assign halt_hit    = halt_req & dbg_mode;
   // Counting is live from the first enabled cycle; HALT freezes from the edge that raises halt_ack.
   assign run         = timer_en && (state_q != HALT);
   assign disable_clr = !timer_en && (state_q != IDLE);
   assign load        = tdr0_wr_sel | tdr1_wr_sel;

   timer_prescaler #(
      .DIV_MAX (DIV_MAX)
   ) u_prescaler (
      .clk     (clk),
      .rst_n   (rst_n),
      .run     (run),
      .clear   (!timer_en),
      .div_en  (div_en),
      .div_val (div_val),
      .tick    (tick)
   );

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (timer_en)  state_d = RUN;
         RUN:     if (halt_hit)  state_d = HALT;
         HALT:    if (!halt_hit) state_d = RUN;
         default: state_d = IDLE;
      endcase
      if (!timer_en) begin
         state_d = IDLE;
      end
   end

   always_comb begin
      cnt_d = cnt_q;
      if (disable_clr) begin
         cnt_d = '0;
      end else if (load) begin
         for (int b = 0; b < 4; b++) begin
            if (tdr0_wr_sel && pstrb[b]) cnt_d[8*b +: 8]      = wdata[8*b +: 8];
            if (tdr1_wr_sel && pstrb[b]) cnt_d[32 + 8*b +: 8] = wdata[8*b +: 8];
         end
      end else if (tick) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
      // A load swallows the coincident tick, so no increment pulse is reported.
      tick_d = tick && !load && !disable_clr;
      ack_d  = halt_hit;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         tick_q  <= 1'b0;
         ack_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         tick_q  <= tick_d;
         ack_q   <= ack_d;
      end
   end

   assign cnt_value = cnt_q;
   assign cnt_tick  = tick_q;
   assign halt_ack  = ack_q;

endmodule

// File: doc/timer_counter.md
# timer_counter

Counting stage of the APB timer: a 64-bit up-counter with programmable 2^N prescaler and a debug-halt handshake. It sits directly downstream of the timer register block. It consumes the control fields and TDR write strobes and returns the live count (`cnt_value`) and `halt_ack`, so the register-side TDR0/TDR1 always mirror the counter.

## Interface
- `CNT_W`, 64: counter width; fixed at 64 for this timer, checked by assertion.
- `DIV_MAX`, 8: largest legal `div_val`; prescaler width is DIV_MAX bits.
- `clk`  in  1  clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `timer_en`  in  1  counting enable (TCR[0]).
- `div_en`  in  1  prescaler enable (TCR[1]).
- `div_val`  in  4  prescale exponent (TCR[11:8]); the register block guarantees ≤ DIV_MAX.
- `tdr0_wr_sel`, `tdr1_wr_sel`  in  1  APB write selecting TDR0 / TDR1 this cycle.
- `wdata`  in  32  APB write data.
- `pstrb`  in  4  APB byte strobes.
- `halt_req`  in  1  debug halt request (THCSR[0]).
- `dbg_mode`  in  1  system debug-mode indication; a halt is only granted while it is high.
- `cnt_value`  out  64  current count; reset 0.
- `halt_ack`  out  1  halt granted; registered; reset 0.
- `cnt_tick`  out  1  one-cycle pulse on each increment; reset 0.

## Operation
- **States:** IDLE (timer_en=0), RUN, HALT. Reset → IDLE.
  - IDLE→RUN when timer_en=1.
  - RUN→HALT when halt_req & dbg_mode.
  - HALT→RUN when !(halt_req & dbg_mode).
  - Any state→IDLE when timer_en=0.
- **Prescaler:** DIV_MAX-bit counter `pcnt`.
  - With div_en=0, or div_en=1 and div_val=0, a tick occurs every cycle in RUN.
  - Otherwise a tick occurs when pcnt == 2^div_val − 1; pcnt then wraps to 0. Example: div_val=8 gives one tick per 256 cycles.
  - pcnt is held at 0 in IDLE.
  - pcnt is frozen (not cleared) in HALT.
- **Counter:** on a tick, cnt_value ← cnt_value + 1, modulo 2^64. 0xFFFF_FFFF_FFFF_FFFF wraps to 0 with no flag.
- **Disable:** on the RUN/HALT→IDLE transition (timer_en 1→0), cnt_value clears to 0 and pcnt clears to 0.
- **Load:**
  - tdr0_wr_sel writes the bytes of cnt_value[31:0] whose pstrb bit is 1 from wdata; tdr1_wr_sel does the same for cnt_value[63:32].
  - Unstrobed bytes keep their current value; they are not incremented on that cycle.
  - A load is legal in every state.
- **Priority per cycle:** disable-clear > load > tick. A load coinciding with a tick writes the loaded bytes and suppresses that increment. The tick is consumed and pcnt still advances/wraps normally.
- **Halt:**
  - halt_ack ← halt_req & dbg_mode, registered.
  - In HALT, cnt_value and pcnt hold and cnt_tick stays 0.
  - halt_req while dbg_mode=0 is ignored; halt_ack stays 0.
- **div_en/div_val changes** are only legal while timer_en=0 (enforced upstream by pslverr). The block samples them combinationally each cycle.

## Timing
- A tick decided in cycle N updates cnt_value at the edge ending cycle N. cnt_tick is high during cycle N+1, aligned with the new value.
- First increment after timer_en rises (div off) occurs at the 1st edge with timer_en=1 sampled high.
- A load is visible on cnt_value one edge after the tdr*_wr_sel cycle. This is the same edge on which the register block captures TDR, so both agree.
- halt_ack rises one edge after halt_req & dbg_mode. The counter freezes from that same edge, so at most one increment lands after the request.
- Resume: counting restarts on the edge after halt_ack falls.
- Reset mid-operation: all state, pcnt, cnt_value, halt_ack and cnt_tick go to 0 immediately, independent of clk.

## Structure
- Shared package `timer_pkg`:
  - CNT_W, DIV_MAX, TCR/TDR/THCSR address constants (shared with the register block).
  - `cnt_state_t` enum {IDLE, RUN, HALT}.
- One sub-module `timer_prescaler`:
  - Inputs: clk, rst_n, run, clear, div_en, div_val.
  - Output: `tick`.
  - Encapsulates pcnt and the terminal-count compare.
- Top level holds the FSM, the 64-bit counter with byte-lane load mux, and the halt_ack flop.

## Test plan
- **Reset/basic count:** release reset, timer_en=1, div_en=0 for 10 cycles → cnt_value=10, cnt_tick high every cycle, halt_ack=0.
- **Prescale:** div_en=1, div_val=2, timer_en=1 for 16 cycles → cnt_value=4, ticks spaced 4 cycles. Repeat with div_val=8 for 512 cycles → 2.
- **Byte load + wrap:** tdr0 write 0xFFFF_FFFF (pstrb=0xF), then tdr1 write 0xFFFF_FFFF while running, div off → next cycle count = 0xFFFF_FFFF_FFFF_FFFF, the following cycle 0. Also tdr0 write pstrb=0x2, wdata=0x0000_AB00 onto 0x1234_5678 → 0x1234_AB78 with no increment that cycle.
- **Halt:**
  - halt_req=1, dbg_mode=1 at count 100 → halt_ack=1 next edge, count frozen at ≤101 for 20 cycles; deassert → counting resumes.
  - halt_req=1, dbg_mode=0 → halt_ack stays 0 and the count continues.
- **Disable:** at count 50 with pcnt mid-period, drop timer_en → cnt_value=0 next edge. Re-enable → the first tick comes a full 2^div_val cycles later.
- **Async reset** asserted mid-count in HALT → all outputs 0 without a clock edge.
